// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destination records; emits forward selects, load-use stall, redirect flush.
module hazard_fwd_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic [4:0]       wr_id,
  input  logic             regwrite_id,
  input  logic             memtoreg_id,
  input  logic             jal_id,
  input  logic             redirect_ex,
  output logic [3:0]       forward,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned RW = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_DIN = 2'd2;
  localparam logic [1:0] FWD_PC4 = 2'd3;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          rs_used;
    logic          rt_used;
    logic [RW-1:0] wr;
    logic          regwrite;
    logic          load;
    logic          jal;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  stage_rec_t ex_q, ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q, wb_d;
  stage_rec_t id_rec;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard_rs;
  logic hazard_rt;

  // WB source fields are carried for completeness but never consumed downstream.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs, wb_q.rt, wb_q.rs_used, wb_q.rt_used,
                              wb_q.load, wb_q.jal};

  // $0 is hardwired, so it is never a producer.
  function automatic logic is_writer(input stage_rec_t s, input logic [RW-1:0] r);
    return s.valid & s.regwrite & (s.wr == r) & (r != '0);
  endfunction

  // Youngest producer wins; a MEM load cannot feed EX and is skipped.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [RW-1:0] r,
                                         input stage_rec_t m, input stage_rec_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used) begin
      if (is_writer(m, r) && m.jal) begin
        sel = FWD_PC4;
      end else if (is_writer(m, r) && !m.load) begin
        sel = FWD_ALU;
      end else if (is_writer(w, r)) begin
        sel = FWD_DIN;
      end
    end
    return sel;
  endfunction

  // Operand forwarding from the registered EX record only.
  always_comb begin
    forward      = '0;
    forward[1:0] = fwd_sel(ex_q.rs_used, ex_q.rs, mem_q, wb_q);
    forward[3:2] = fwd_sel(ex_q.rt_used, ex_q.rt, mem_q, wb_q);
  end

  // Load-use detection against the ID operands; redirect suppresses it.
  always_comb begin
    hazard_rs = rs_used_id & (rs_id == ex_q.wr);
    hazard_rt = rt_used_id & (rt_id == ex_q.wr);
    stall     = en & ~redirect_ex & ex_q.valid & ex_q.load & (ex_q.wr != '0)
              & (hazard_rs | hazard_rt);
    flush     = en & redirect_ex;
  end

  always_comb begin
    id_rec          = BUBBLE;
    id_rec.valid    = 1'b1;
    id_rec.rs       = rs_id;
    id_rec.rt       = rt_id;
    id_rec.rs_used  = rs_used_id;
    id_rec.rt_used  = rt_used_id;
    id_rec.wr       = wr_id;
    id_rec.regwrite = regwrite_id;
    id_rec.load     = memtoreg_id;
    id_rec.jal      = jal_id;
  end

  // Pipeline record advance and event counters; everything holds when en=0.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (en) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (stall | flush) ? BUBBLE : id_rec;
      stall_cnt_d = stall_cnt_q + CNT_W'(stall);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit.
module tb_hazard_fwd_unit;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             rs_used_id;
  logic             rt_used_id;
  logic [4:0]       wr_id;
  logic             regwrite_id;
  logic             memtoreg_id;
  logic             jal_id;
  logic             redirect_ex;
  logic [3:0]       forward;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int total;
  int bad;

  hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .rs_used_id  (rs_used_id),
    .rt_used_id  (rt_used_id),
    .wr_id       (wr_id),
    .regwrite_id (regwrite_id),
    .memtoreg_id (memtoreg_id),
    .jal_id      (jal_id),
    .redirect_ex (redirect_ex),
    .forward     (forward),
    .stall       (stall),
    .flush       (flush),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive the ID-stage instruction fields and let the combinational outputs settle.
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic [4:0] wr, input logic rw,
                        input logic ld, input logic jl);
    rs_id = rs; rt_id = rt; rs_used_id = rsu; rt_used_id = rtu;
    wr_id = wr; regwrite_id = rw; memtoreg_id = ld; jal_id = jl;
    #1;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b1; redirect_ex = 1'b0;
    nop();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_fwd",   32'(forward),   32'h0);
    chk("rst_stall", 32'(stall),     32'h0);
    chk("rst_flush", 32'(flush),     32'h0);
    chk("rst_scnt",  32'(stall_cnt), 32'h0);
    chk("rst_fcnt",  32'(flush_cnt), 32'h0);

    // add $3,$1,$2 ; add $4,$3,$3 ; add $5,$3,$0 ; add $10,$3,$4
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("alu_nostall", 32'(stall), 32'h0);
    tick();
    set_id(5'd3, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("fwd_dist1", 32'(forward), 32'h5);
    tick();
    set_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("fwd_dist2", 32'(forward), 32'h2);
    tick();
    nop();
    chk("fwd_dist3_mix", 32'(forward), 32'h8);
    drain();

    // lw $5,0($0) ; add $6,$5,$7
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 32'(stall), 32'h1);
    tick();
    chk("lu_stall_once", 32'(stall), 32'h0);
    chk("lu_scnt", 32'(stall_cnt), 32'h1);
    chk("lu_bubble_fwd", 32'(forward), 32'h0);
    tick();
    nop();
    chk("lu_fwd_din", 32'(forward), 32'h2);
    drain();
    chk("lu_scnt_hold", 32'(stall_cnt), 32'h1);

    // jal target ; addu $8,$31,$0
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd31, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    chk("jal_fwd", 32'(forward), 32'h3);
    drain();

    // addi $0,$1,5 ; add $9,$0,$0
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("r0_nostall", 32'(stall), 32'h0);
    tick();
    nop();
    chk("r0_fwd", 32'(forward), 32'h0);
    drain();
    // lw $0 ; reader of $0
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    chk("lw_r0_nostall", 32'(stall), 32'h0);
    drain();

    // lw $5 in EX, reader of $5 in ID, redirect active
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    redirect_ex = 1'b1;
    #1;
    chk("redir_nostall", 32'(stall), 32'h0);
    chk("redir_flush",   32'(flush), 32'h1);
    tick();
    redirect_ex = 1'b0;
    nop();
    chk("redir_fcnt",    32'(flush_cnt), 32'h1);
    chk("redir_scnt",    32'(stall_cnt), 32'h1);
    chk("redir_bubble",  32'(forward),   32'h0);
    chk("redir_flush_off", 32'(flush),   32'h0);
    drain();

    // add $11,$1,$2 ; lw $13,0($11) ; add $14,$13,$0 with a 3-cycle freeze
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd11, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd13, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    chk("frz_pre_fwd", 32'(forward), 32'h1);
    chk("frz_pre_stall", 32'(stall), 32'h1);
    en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      redirect_ex = (i == 1);
      #1;
      chk("frz_stall", 32'(stall), 32'h0);
      chk("frz_flush", 32'(flush), 32'h0);
      tick();
      chk("frz_fwd",  32'(forward),   32'h1);
      chk("frz_scnt", 32'(stall_cnt), 32'h1);
      chk("frz_fcnt", 32'(flush_cnt), 32'h1);
    end
    redirect_ex = 1'b0;
    en = 1'b1;
    #1;
    chk("frz_resume_stall", 32'(stall), 32'h1);
    tick();
    chk("frz_resume_scnt", 32'(stall_cnt), 32'h2);
    chk("frz_resume_once", 32'(stall), 32'h0);
    tick();
    nop();
    chk("frz_resume_fwd", 32'(forward), 32'h2);
    drain();

    // add $15 ; add $16,$15 ; reset while consumer is in EX
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd15, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    chk("pre_rst_fwd", 32'(forward), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_fwd",  32'(forward),   32'h0);
    chk("mid_rst_scnt", 32'(stall_cnt), 32'h0);
    chk("mid_rst_fcnt", 32'(flush_cnt), 32'h0);

    // reset during a load-use stall loses the hazard
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd20, 5'd0, 1'b1, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0);
    chk("rst_stall_pre", 32'(stall), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall_post", 32'(stall),     32'h0);
    chk("rst_stall_scnt", 32'(stall_cnt), 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Pipeline hazard and forwarding controller for the 5-stage MIPS core. It tracks the destination-register records of the instructions in EX, MEM and WB. From those records it produces the 4-bit forwarding select consumed by the EX-stage operand relocation mux. It also detects load-use hazards (stall) and control redirects (flush), and keeps stall/flush event counters for the debug display.

## Interface
- Parameters:
  - CNT_W, default 16: width of the stall/flush event counters.
- Ports:
  - clk  in  1  core clock; all state updates on rising edge.
  - rst  in  1  synchronous, active-high reset.
  - en  in  1  pipeline advance enable (~halt | Go); 0 freezes all state.
  - rs_id  in  5  ID-stage source 1 register, after syscall remap ($2).
  - rt_id  in  5  ID-stage source 2 register, after syscall remap ($4).
  - rs_used_id  in  1  ID instruction actually reads rs.
  - rt_used_id  in  1  ID instruction actually reads rt.
  - wr_id  in  5  ID-stage write register (rt, rd or 31 already selected).
  - regwrite_id  in  1  ID instruction writes the register file.
  - memtoreg_id  in  1  ID instruction is a load.
  - jal_id  in  1  ID instruction is JAL (writes PC+4).
  - redirect_ex  in  1  EX-stage taken branch/jump; younger instructions are wrong-path.
  - forward  out  4  [1:0] selects R1 source, [3:2] selects R2 source: 0 = regfile, 1 = ALUres_MEM, 2 = Din_WB, 3 = PC_plus_4_MEM.
  - stall  out  1  hold PC and IF/ID; ID/EX receives a bubble.
  - flush  out  1  squash IF/ID and ID/EX contents.
  - stall_cnt  out  CNT_W  count of cycles stalled.
  - flush_cnt  out  CNT_W  count of redirect flushes.

## Operation
- Each of the EX, MEM and WB stages holds a record: valid, rs, rt, rs_used, rt_used, wr, regwrite, load, jal. A bubble is a record with all bits 0.
- Record advance, on the clock edge when en=1:
  - WB<=MEM
  - MEM<=EX
  - EX<=bubble if (stall | flush), else the ID inputs with valid=1.
- When en=0, every record and counter holds.
- "Writer" definition: a stage is a writer of register r iff valid & regwrite & wr==r & r!=0. Register $0 never forwards and never stalls.
- Forward select, R1 (computed from the EX record; R2 is identical using rt/rt_used and bits [3:2]):
  - If rs_used=0, select 0.
  - Else if MEM is a writer and MEM.jal=1, select 3.
  - Else if MEM is a writer and MEM.load=0, select 1.
  - Else if WB is a writer, select 2.
  - Else select 0.
  - MEM beats WB (the youngest producer wins).
  - A MEM-stage load match is unreachable because stall prevents it. If it occurs anyway, the MEM entry is ignored and the WB/regfile rule applies.
- stall = en & ~redirect_ex & EX.valid & EX.load & EX.wr!=0 & ((rs_used_id & rs_id==EX.wr) | (rt_used_id & rt_id==EX.wr)).
- flush = en & redirect_ex. Redirect has priority: a wrong-path load-use hazard never stalls.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - Both wrap modulo 2^CNT_W.
- A write by WB and a read by ID of the same register in the same cycle is resolved by the write-first register file, not by this block.

## Timing
- forward, stall and flush are combinational. forward depends on the registered records only. stall and flush also depend on the same-cycle ID/EX inputs.
- Load-use costs exactly one stall cycle. In the next cycle the load is in MEM, the bubble is in EX, and the consumer stays in ID. One cycle later the consumer is in EX with forward = 2 (Din_WB).
- Distance-1 ALU producer → forward 1. Distance-2 producer → forward 2. Distance ≥3 → 0 (regfile).
- Reset (rst=1 at an edge, regardless of en): all records become bubbles and stall_cnt = flush_cnt = 0. Consequently forward=0, and stall=0. flush follows redirect_ex & en.
- Reset mid-stall: the stalled consumer's hazard record is lost. Upstream stages reset concurrently, so no pending hazard survives.
- The flush cycle inserts a bubble into EX even if a stall condition also holds.

## Test plan
- add $3,$1,$2 then add $4,$3,$3 back-to-back → forward=4'b0101 in the consumer's EX cycle. Then nop, add $5,$3,$0 at distance 2 → forward[1:0]=2, forward[3:2]=0.
- lw $5,0($0) then add $6,$5,$7 → stall=1 for exactly one cycle and stall_cnt=1. In the consumer's EX cycle forward=4'b0010.
- jal target then (in the delay slot/target) addu $8,$31,$0 → forward[1:0]=3.
- addi $0,$1,5 then add $9,$0,$0 → forward=0 and stall=0. lw $0 followed by a reader of $0 → stall=0.
- lw $5 in EX with an ID reader of $5 while redirect_ex=1 → stall=0, flush=1, flush_cnt increments by 1, and the next EX record is a bubble (forward=0 the following cycle).
- en=0 for 3 cycles during a pending distance-1 hazard → records, forward and counters unchanged, stall=0. Then en=1 → behaviour resumes as if uninterrupted. Also assert rst mid-sequence → forward=0 and counters=0 on the next cycle.
